// File: rtl/fb_fill_arbiter.sv
// Rectangle fill engine sharing one frame-buffer write port with a single-pixel
// client. The client always wins; the fill cursor only moves on cycles it owns.
module fb_fill_arbiter #(
  parameter int FB_W = 320,
  parameter int FB_H = 240
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [8:0]  rect_x,
  input  logic [7:0]  rect_y,
  input  logic [8:0]  rect_w,
  input  logic [7:0]  rect_h,
  input  logic [7:0]  rect_color,
  output logic        busy,
  output logic        done,
  input  logic        cli_req,
  input  logic [8:0]  cli_x,
  input  logic [7:0]  cli_y,
  input  logic [7:0]  cli_color,
  output logic        cli_ack,
  output logic [16:0] fb_wraddress,
  output logic [7:0]  fb_data,
  output logic        fb_wren
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t      state_q, state_d;
  logic [9:0]  rx_q, rx_d;
  logic [9:0]  ex_q, ex_d;
  logic [9:0]  ey_q, ey_d;
  logic [7:0]  color_q, color_d;
  logic [9:0]  cx_q, cx_d;
  logic [9:0]  cy_q, cy_d;
  logic [16:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic        wren_q, wren_d;

  logic        fillGrant;
  logic        lastPixel;

  function automatic logic [16:0] pixelAddr(input logic [9:0] x, input logic [9:0] y);
    logic [31:0] full;
    full = 32'(y) * 32'(FB_W) + 32'(x);
    return full[16:0];
  endfunction

  function automatic logic inBounds(input logic [9:0] x, input logic [9:0] y);
    return (32'(x) < 32'(FB_W)) && (32'(y) < 32'(FB_H));
  endfunction

  assign cli_ack   = cli_req & ~reset;
  assign fillGrant = (state_q == FILL) && !cli_req;
  assign lastPixel = (cx_q == ex_q) && (cy_q == ey_q);

  assign busy         = (state_q == FILL);
  assign done         = (state_q == DONE);
  assign fb_wraddress = addr_q;
  assign fb_data      = data_q;
  assign fb_wren      = wren_q;

  always_comb begin
    state_d = state_q;
    rx_d    = rx_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    color_d = color_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;

    // Out-of-range pixels still take their grant; only the write strobe is withheld.
    if (cli_req) begin
      if (inBounds({1'b0, cli_x}, {2'b00, cli_y})) begin
        wren_d = 1'b1;
        addr_d = pixelAddr({1'b0, cli_x}, {2'b00, cli_y});
        data_d = cli_color;
      end
    end else if (fillGrant) begin
      if (inBounds(cx_q, cy_q)) begin
        wren_d = 1'b1;
        addr_d = pixelAddr(cx_q, cy_q);
        data_d = color_q;
      end
      if (cx_q == ex_q) begin
        cx_d = rx_q;
        cy_d = cy_q + 10'd1;
      end else begin
        cx_d = cx_q + 10'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          rx_d    = {1'b0, rect_x};
          ex_d    = {1'b0, rect_x} + {1'b0, rect_w} - 10'd1;
          ey_d    = {2'b00, rect_y} + {2'b00, rect_h} - 10'd1;
          color_d = rect_color;
          cx_d    = {1'b0, rect_x};
          cy_d    = {2'b00, rect_y};
          if (rect_w == 9'd0 || rect_h == 8'd0) begin
            state_d = DONE;
          end else begin
            state_d = FILL;
          end
        end
      end
      FILL: begin
        if (fillGrant && lastPixel) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rx_q    <= '0;
      ex_q    <= '0;
      ey_q    <= '0;
      color_q <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rx_q    <= rx_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      color_q <= color_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
    end
  end

endmodule

// File: tb/tb_fb_fill_arbiter.sv
// Scoreboard bench for fb_fill_arbiter: expected writes are queued by the stimulus
// thread and retired by a monitor whenever the write port strobes.
module tb_fb_fill_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  rect_x;
  logic [7:0]  rect_y;
  logic [8:0]  rect_w;
  logic [7:0]  rect_h;
  logic [7:0]  rect_color;
  logic        busy;
  logic        done;
  logic        cli_req;
  logic [8:0]  cli_x;
  logic [7:0]  cli_y;
  logic [7:0]  cli_color;
  logic        cli_ack;
  logic [16:0] fb_wraddress;
  logic [7:0]  fb_data;
  logic        fb_wren;

  typedef struct {
    logic [16:0] addr;
    logic [7:0]  data;
    logic        last;
  } wr_t;

  wr_t expQ[$];
  wr_t monE;
  int  checks = 0;
  int  failures = 0;
  int  bareDone = 0;
  int  bc;

  fb_fill_arbiter #(.FB_W(320), .FB_H(240)) dut (
    .clock(clock), .reset(reset), .start(start),
    .rect_x(rect_x), .rect_y(rect_y), .rect_w(rect_w), .rect_h(rect_h),
    .rect_color(rect_color), .busy(busy), .done(done),
    .cli_req(cli_req), .cli_x(cli_x), .cli_y(cli_y), .cli_color(cli_color),
    .cli_ack(cli_ack), .fb_wraddress(fb_wraddress), .fb_data(fb_data),
    .fb_wren(fb_wren)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic pushWr(input logic [16:0] addr, input logic [7:0] data, input logic last);
    wr_t e;
    e.addr = addr;
    e.data = data;
    e.last = last;
    expQ.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [8:0] x, input logic [7:0] y, input logic [8:0] w,
                               input logic [7:0] h, input logic [7:0] c);
    rect_x = x;
    rect_y = y;
    rect_w = w;
    rect_h = h;
    rect_color = c;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic waitDone(output int busyCycles);
    bit seen;
    seen = 1'b0;
    busyCycles = 0;
    for (int i = 0; i < 60 && !seen; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (busy === 1'b1) busyCycles++;
        tick();
      end
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout actual=no_done expected=done_within_60");
    end
  endtask

  // Every strobe must match the head of the queue; done must coincide with the last write
  always @(negedge clock) begin
    if (fb_wren === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_write actual=%0d expected=no_write", fb_wraddress);
      end else begin
        monE = expQ.pop_front();
        checkOutput("wr_addr", 32'(fb_wraddress), 32'(monE.addr));
        checkOutput("wr_data", 32'(fb_data), 32'(monE.data));
        checkOutput("done_with_write", 32'(done), 32'(monE.last));
      end
    end else if (done === 1'b1) begin
      checks++;
      if (bareDone == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_done actual=1 expected=0");
      end else begin
        bareDone--;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; rect_color = '0;
    cli_req = 1'b1; cli_x = 9'd5; cli_y = 8'd7; cli_color = 8'hEE;
    tick();
    tick();
    $display("[TB] reset state");
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_wren", 32'(fb_wren), 0);
    checkOutput("rst_addr", 32'(fb_wraddress), 0);
    checkOutput("rst_data", 32'(fb_data), 0);
    checkOutput("rst_cli_ack", 32'(cli_ack), 0);
    cli_req = 1'b0;
    reset = 1'b0;
    tick();

    $display("[TB] basic 3x2 fill");
    pushWr(17'd1610, 8'h1F, 1'b0);
    pushWr(17'd1611, 8'h1F, 1'b0);
    pushWr(17'd1612, 8'h1F, 1'b0);
    pushWr(17'd1930, 8'h1F, 1'b0);
    pushWr(17'd1931, 8'h1F, 1'b0);
    pushWr(17'd1932, 8'h1F, 1'b1);
    applyStimulus(9'd10, 8'd5, 9'd3, 8'd2, 8'h1F);
    waitDone(bc);
    checkOutput("basic_busy_cycles", 32'(bc), 6);
    checkOutput("basic_busy_in_done", 32'(busy), 0);
    tick();
    checkOutput("hold_wren", 32'(fb_wren), 0);
    checkOutput("hold_addr", 32'(fb_wraddress), 1932);
    checkOutput("hold_data", 32'(fb_data), 32'h1F);
    checkOutput("idle_done", 32'(done), 0);

    $display("[TB] client preempts 2x2 fill");
    pushWr(17'd0, 8'h22, 1'b0);
    pushWr(17'd2245, 8'hAA, 1'b0);
    pushWr(17'd2245, 8'hAA, 1'b0);
    pushWr(17'd2245, 8'hAA, 1'b0);
    pushWr(17'd1, 8'h22, 1'b0);
    pushWr(17'd320, 8'h22, 1'b0);
    pushWr(17'd321, 8'h22, 1'b1);
    applyStimulus(9'd0, 8'd0, 9'd2, 8'd2, 8'h22);
    tick();
    cli_req = 1'b1; cli_x = 9'd5; cli_y = 8'd7; cli_color = 8'hAA;
    #1;
    checkOutput("cli_ack_during_fill", 32'(cli_ack), 1);
    checkOutput("busy_during_client", 32'(busy), 1);
    tick();
    tick();
    tick();
    cli_req = 1'b0;
    waitDone(bc);
    checkOutput("resume_busy_cycles", 32'(bc), 3);
    tick();

    $display("[TB] clipped fill at frame corner");
    pushWr(17'd76798, 8'h33, 1'b0);
    pushWr(17'd76799, 8'h33, 1'b0);
    bareDone++;
    applyStimulus(9'd318, 8'd239, 9'd4, 8'd2, 8'h33);
    waitDone(bc);
    checkOutput("clip_busy_cycles", 32'(bc), 8);
    tick();

    $display("[TB] zero-width fill");
    bareDone++;
    applyStimulus(9'd0, 8'd0, 9'd0, 8'd4, 8'h77);
    checkOutput("zero_done", 32'(done), 1);
    checkOutput("zero_busy", 32'(busy), 0);
    tick();
    checkOutput("zero_done_after", 32'(done), 0);

    $display("[TB] start ignored while busy and in done");
    pushWr(17'd322, 8'h44, 1'b0);
    pushWr(17'd323, 8'h44, 1'b0);
    pushWr(17'd324, 8'h44, 1'b1);
    applyStimulus(9'd2, 8'd1, 9'd3, 8'd1, 8'h44);
    tick();
    applyStimulus(9'd100, 8'd100, 9'd5, 8'd5, 8'h99);
    waitDone(bc);
    checkOutput("ignore_busy_cycles", 32'(bc), 1);
    applyStimulus(9'd50, 8'd50, 9'd2, 8'd2, 8'h12);
    checkOutput("start_in_done_busy", 32'(busy), 0);
    checkOutput("start_in_done_done", 32'(done), 0);
    tick();
    checkOutput("start_in_done_busy2", 32'(busy), 0);

    $display("[TB] client writes with clipping");
    pushWr(17'd76799, 8'h5A, 1'b0);
    cli_req = 1'b1; cli_x = 9'd319; cli_y = 8'd239; cli_color = 8'h5A;
    tick();
    cli_x = 9'd320; cli_y = 8'd0; cli_color = 8'h01;
    #1;
    checkOutput("cli_ack_clipped", 32'(cli_ack), 1);
    tick();
    cli_x = 9'd0; cli_y = 8'd240; cli_color = 8'h02;
    tick();
    cli_req = 1'b0;
    tick();
    tick();
    checkOutput("cli_clip_wren", 32'(fb_wren), 0);
    checkOutput("cli_clip_addr_hold", 32'(fb_wraddress), 76799);

    $display("[TB] reset during fill");
    pushWr(17'd3200, 8'h55, 1'b0);
    pushWr(17'd3201, 8'h55, 1'b0);
    applyStimulus(9'd0, 8'd10, 9'd3, 8'd3, 8'h55);
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("midrst_busy", 32'(busy), 0);
    checkOutput("midrst_wren", 32'(fb_wren), 0);
    checkOutput("midrst_done", 32'(done), 0);
    reset = 1'b0;
    tick();
    tick();
    tick();
    pushWr(17'd319, 8'h66, 1'b1);
    applyStimulus(9'd319, 8'd0, 9'd1, 8'd1, 8'h66);
    waitDone(bc);
    checkOutput("post_rst_busy_cycles", 32'(bc), 1);
    tick();
    tick();

    checkOutput("queue_drained", 32'(expQ.size()), 0);
    checkOutput("bare_done_consumed", 32'(bareDone), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
